// File: rtl/pl_id_ex_register.sv
// Decode->Execute pipeline register for the pipelined RV32I core.
// Registers the D-stage bundle into E. Load, stall, flush and bubble
// counting are handled here. The two source-operand lanes apply the
// write-through bypass, which covers two cases:
//   - on a load, a WB write to a source register the decoder is reading;
//   - during a stall, a WB write to a source register already held in E.

// Per-operand lane.
// Produces two candidate values for the operand:
//   - the value to capture on a normal load (D read data, or WB bypass);
//   - the value to keep while stalled (held data, or a WB refresh).
module pl_id_ex_opnd #(
  parameter int WAD = 5,
  parameter int WD  = 32
) (
  input  logic [WAD-1:0] rs_d_i,
  input  logic [WD-1:0]  rdat_d_i,
  input  logic [WAD-1:0] rs_e_i,
  input  logic [WD-1:0]  rdat_e_i,
  input  logic           wb_we_i,
  input  logic [WAD-1:0] wb_rd_i,
  input  logic [WD-1:0]  wb_data_i,
  output logic [WD-1:0]  ld_o,
  output logic [WD-1:0]  hold_o
);
  logic wb_live;
  logic hit_d;
  logic hit_e;

  // x0 writes are architecturally discarded, so they never forward.
  assign wb_live = wb_we_i && (wb_rd_i != '0);
  assign hit_d   = wb_live && (wb_rd_i == rs_d_i);
  assign hit_e   = wb_live && (wb_rd_i == rs_e_i);

  assign ld_o   = hit_d ? wb_data_i : rdat_d_i;
  assign hold_o = hit_e ? wb_data_i : rdat_e_i;
endmodule

module pl_id_ex_register #(
  parameter int WAD = 5,
  parameter int WD  = 32,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           StallE,
  input  logic           FlushE,
  input  logic           ValidD,
  input  logic [WAD-1:0] Rs1D,
  input  logic [WAD-1:0] Rs2D,
  input  logic [WAD-1:0] RdD,
  input  logic [WD-1:0]  RD1D,
  input  logic [WD-1:0]  RD2D,
  input  logic [WD-1:0]  ImmExtD,
  input  logic [WD-1:0]  PCD,
  input  logic [WD-1:0]  PCPlus4D,
  input  logic           RegWriteD,
  input  logic           MemWriteD,
  input  logic           JumpD,
  input  logic           BranchD,
  input  logic           ALUSrcD,
  input  logic [1:0]     ResultSrcD,
  input  logic [3:0]     ALUControlD,
  input  logic           RegWriteW,
  input  logic [WAD-1:0] RdW,
  input  logic [WD-1:0]  ResultW,
  output logic           ValidE,
  output logic [WAD-1:0] Rs1E,
  output logic [WAD-1:0] Rs2E,
  output logic [WAD-1:0] RdE,
  output logic [WD-1:0]  RD1E,
  output logic [WD-1:0]  RD2E,
  output logic [WD-1:0]  ImmExtE,
  output logic [WD-1:0]  PCE,
  output logic [WD-1:0]  PCPlus4E,
  output logic           RegWriteE,
  output logic           MemWriteE,
  output logic           JumpE,
  output logic           BranchE,
  output logic           ALUSrcE,
  output logic [1:0]     ResultSrcE,
  output logic [3:0]     ALUControlE,
  output logic [CW-1:0]  BubbleCnt
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic           valid;
    logic           regwrite;
    logic           memwrite;
    logic           jump;
    logic           branch;
    logic           alusrc;
    logic [1:0]     resultsrc;
    logic [3:0]     aluctl;
    logic [WAD-1:0] rs1;
    logic [WAD-1:0] rs2;
    logic [WAD-1:0] rd;
    logic [WD-1:0]  rd1;
    logic [WD-1:0]  rd2;
    logic [WD-1:0]  imm;
    logic [WD-1:0]  pc;
    logic [WD-1:0]  pc4;
  } ex_t;

  ex_t                            ex_q;
  ex_t                            ex_d;
  logic [CW-1:0]                  bub_q;
  logic [CW-1:0]                  bub_d;

  logic [NUM_OPS-1:0][WAD-1:0]    rs_d;
  logic [NUM_OPS-1:0][WAD-1:0]    rs_e;
  logic [NUM_OPS-1:0][WD-1:0]     rdat_d;
  logic [NUM_OPS-1:0][WD-1:0]     rdat_e;
  logic [NUM_OPS-1:0][WD-1:0]     ld_val;
  logic [NUM_OPS-1:0][WD-1:0]     hold_val;

  assign rs_d   = {Rs2D, Rs1D};
  assign rs_e   = {ex_q.rs2, ex_q.rs1};
  assign rdat_d = {RD2D, RD1D};
  assign rdat_e = {ex_q.rd2, ex_q.rd1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    pl_id_ex_opnd #(.WAD(WAD), .WD(WD)) u_op (
      .rs_d_i    (rs_d[g]),
      .rdat_d_i  (rdat_d[g]),
      .rs_e_i    (rs_e[g]),
      .rdat_e_i  (rdat_e[g]),
      .wb_we_i   (RegWriteW),
      .wb_rd_i   (RdW),
      .wb_data_i (ResultW),
      .ld_o      (ld_val[g]),
      .hold_o    (hold_val[g])
    );
  end

  // Next E contents. Flush beats stall beats load; a stalled entry only
  // changes through the WB refresh of its operands.
  always_comb begin
    ex_d = ex_q;
    if (FlushE) begin
      ex_d = '0;
    end else if (StallE) begin
      ex_d.rd1 = hold_val[0];
      ex_d.rd2 = hold_val[1];
    end else begin
      ex_d.valid     = ValidD;
      ex_d.regwrite  = RegWriteD;
      ex_d.memwrite  = MemWriteD;
      ex_d.jump      = JumpD;
      ex_d.branch    = BranchD;
      ex_d.alusrc    = ALUSrcD;
      ex_d.resultsrc = ResultSrcD;
      ex_d.aluctl    = ALUControlD;
      ex_d.rs1       = Rs1D;
      ex_d.rs2       = Rs2D;
      ex_d.rd        = RdD;
      ex_d.rd1       = ld_val[0];
      ex_d.rd2       = ld_val[1];
      ex_d.imm       = ImmExtD;
      ex_d.pc        = PCD;
      ex_d.pc4       = PCPlus4D;
    end
  end

  // Bubble counter: counts flushes and sticks at all-ones.
  always_comb begin
    bub_d = bub_q;
    if (FlushE && (bub_q != '1)) bub_d = bub_q + CW'(1);
  end

  // State registers; reset clears the entry immediately, even mid-stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      bub_q <= '0;
    end else begin
      ex_q  <= ex_d;
      bub_q <= bub_d;
    end
  end

  assign ValidE      = ex_q.valid;
  assign RegWriteE   = ex_q.regwrite;
  assign MemWriteE   = ex_q.memwrite;
  assign JumpE       = ex_q.jump;
  assign BranchE     = ex_q.branch;
  assign ALUSrcE     = ex_q.alusrc;
  assign ResultSrcE  = ex_q.resultsrc;
  assign ALUControlE = ex_q.aluctl;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign ImmExtE     = ex_q.imm;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc4;
  assign BubbleCnt   = bub_q;
endmodule

// File: tb/tb_pl_id_ex_register.sv
// Scoreboard bench for pl_id_ex_register (CW=2 so saturation is reachable).
// Stimulus pushes the expected E bundle after each edge; the monitor pops
// and compares on the following falling edge.
module tb_pl_id_ex_register;
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memwrite;
    logic        jump;
    logic        branch;
    logic        alusrc;
    logic [1:0]  resultsrc;
    logic [3:0]  aluctl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
  } pl_t;

  typedef struct packed {
    pl_t        p;
    logic [1:0] cnt;
  } out_t;

  typedef struct {
    out_t  exp;
    string name;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        rw;
  logic [4:0]  rdw;
  logic [31:0] resw;
  pl_t         d;

  logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [1:0]  BubbleCnt;
  out_t        act;

  sb_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  pl_id_ex_register #(.WAD(5), .WD(32), .CW(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .StallE      (stall),
    .FlushE      (flush),
    .ValidD      (d.valid),
    .Rs1D        (d.rs1),
    .Rs2D        (d.rs2),
    .RdD         (d.rd),
    .RD1D        (d.rd1),
    .RD2D        (d.rd2),
    .ImmExtD     (d.imm),
    .PCD         (d.pc),
    .PCPlus4D    (d.pc4),
    .RegWriteD   (d.regwrite),
    .MemWriteD   (d.memwrite),
    .JumpD       (d.jump),
    .BranchD     (d.branch),
    .ALUSrcD     (d.alusrc),
    .ResultSrcD  (d.resultsrc),
    .ALUControlD (d.aluctl),
    .RegWriteW   (rw),
    .RdW         (rdw),
    .ResultW     (resw),
    .ValidE      (ValidE),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .ImmExtE     (ImmExtE),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .JumpE       (JumpE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .ResultSrcE  (ResultSrcE),
    .ALUControlE (ALUControlE),
    .BubbleCnt   (BubbleCnt)
  );

  assign act = {ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
                ResultSrcE, ALUControlE, Rs1E, Rs2E, RdE,
                RD1E, RD2E, ImmExtE, PCE, PCPlus4E, BubbleCnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected bundle per falling edge while any are pending.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t it;
      it = sb.pop_front();
      n_vec++;
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  function automatic pl_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] rd1,
                             input logic [31:0] rd2, input logic [31:0] tag);
    pl_t r;
    r.valid     = 1'b1;
    r.regwrite  = 1'b1;
    r.memwrite  = 1'b0;
    r.jump      = 1'b0;
    r.branch    = 1'b1;
    r.alusrc    = 1'b1;
    r.resultsrc = 2'b01;
    r.aluctl    = 4'h5;
    r.rs1       = rs1;
    r.rs2       = rs2;
    r.rd        = rd;
    r.rd1       = rd1;
    r.rd2       = rd2;
    r.imm       = tag;
    r.pc        = tag << 2;
    r.pc4       = (tag << 2) + 32'd4;
    return r;
  endfunction

  function automatic out_t to_e(input pl_t p, input logic [1:0] c);
    out_t e;
    e.p   = p;
    e.cnt = c;
    return e;
  endfunction

  task automatic push(input out_t e, input string name);
    sb_t it;
    it.exp  = e;
    it.name = name;
    sb.push_back(it);
  endtask

  // One clock edge with the current inputs, then expect e on the next fall.
  task automatic apply(input out_t e, input string name);
    @(posedge clk);
    push(e, name);
    @(negedge clk);
    #1;
  endtask

  initial begin
    out_t e;
    out_t hold;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    rw = 1'b0; rdw = '0; resw = '0;

    // Reset with busy D inputs
    d = mk(5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 32'h40);
    d.memwrite = 1'b1;
    apply('0, "reset");

    // First load after release
    rst_n = 1'b1;
    d = mk(5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'h50);
    apply(to_e(d, 2'd0), "load_after_reset");

    // Bypass on both operands, then x0 never forwards
    d = mk(5'd5, 5'd5, 5'd8, 32'hAAAA, 32'hAAAA, 32'h60);
    rw = 1'b1; rdw = 5'd5; resw = 32'h1234;
    e = to_e(d, 2'd0); e.p.rd1 = 32'h1234; e.p.rd2 = 32'h1234;
    apply(e, "bypass_both");
    rdw = 5'd0;
    apply(to_e(d, 2'd0), "bypass_x0");
    d = mk(5'd5, 5'd6, 5'd8, 32'hAAAA, 32'hBBBB, 32'h64);
    rdw = 5'd6; resw = 32'h77;
    e = to_e(d, 2'd0); e.p.rd2 = 32'h77;
    apply(e, "bypass_rs2_only");
    rw = 1'b0; rdw = 5'd5;
    apply(to_e(d, 2'd0), "bypass_we_off");

    // Stall holds everything; WB refreshes only E source operands
    d = mk(5'd2, 5'd7, 5'd10, 32'h22, 32'h1, 32'h70);
    hold = to_e(d, 2'd0);
    apply(hold, "stall_load");
    stall = 1'b1;
    d = mk(5'd7, 5'd9, 5'd11, 32'hDEAD0001, 32'hDEAD0002, 32'h80);
    apply(hold, "stall_c1");
    rw = 1'b1; rdw = 5'd7; resw = 32'h99;
    hold.p.rd2 = 32'h99;
    apply(hold, "stall_c2_refresh");
    rw = 1'b0;
    apply(hold, "stall_c3");
    rw = 1'b1; rdw = 5'd2; resw = 32'h55;
    hold.p.rd1 = 32'h55;
    apply(hold, "stall_refresh_rs1");

    // Flush beats stall
    rw = 1'b0; flush = 1'b1;
    d = mk(5'd1, 5'd2, 5'd9, 32'h5, 32'h6, 32'h90);
    d.memwrite = 1'b1;
    e = '0; e.cnt = 2'd1;
    apply(e, "flush_with_stall");
    flush = 1'b0; stall = 1'b0;
    apply(to_e(d, 2'd1), "load_after_flush");

    // Saturation from a clean counter
    rst_n = 1'b0;
    apply('0, "reset2");
    rst_n = 1'b1; flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e = '0;
      e.cnt = (i < 3) ? 2'(i + 1) : 2'd3;
      apply(e, "flush_sat");
    end
    flush = 1'b0;
    d = mk(5'd4, 5'd8, 5'd12, 32'h123, 32'h456, 32'hA0);
    hold = to_e(d, 2'd3);
    apply(hold, "load_keeps_cnt");

    // Async reset in the middle of a stall
    stall = 1'b1;
    d = mk(5'd13, 5'd14, 5'd15, 32'hCAFE, 32'hF00D, 32'hB0);
    apply(hold, "stall_hold");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push('0, "async_rst_mid_stall");
    @(negedge clk);
    #1;
    stall = 1'b0; rst_n = 1'b1;
    apply(to_e(d, 2'd0), "load_after_async_rst");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
